// File: rtl/teknofest_ram_arbiter.sv
// Two-port (fetch P0 / load-store P1) arbiter onto one RAM; grant is combinational, response 1 cycle later.
// Backpressure: a losing or prog-blocked requester sees gnt=0 and holds its request. RAM_ARB_RR_EN selects round-robin.
module teknofest_ram_arbiter #(
    parameter int          ADDR_W    = 17,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              prog_busy_i,
    input  logic              p0_req_i,
    input  logic              p0_we_i,
    input  logic [31:0]       p0_addr_i,
    input  logic [31:0]       p0_wdata_i,
    input  logic [3:0]        p0_strb_i,
    output logic              p0_gnt_o,
    output logic              p0_rvalid_o,
    output logic [31:0]       p0_rdata_o,
    output logic              p0_err_o,
    input  logic              p1_req_i,
    input  logic              p1_we_i,
    input  logic [31:0]       p1_addr_i,
    input  logic [31:0]       p1_wdata_i,
    input  logic [3:0]        p1_strb_i,
    output logic              p1_gnt_o,
    output logic              p1_rvalid_o,
    output logic [31:0]       p1_rdata_o,
    output logic              p1_err_o,
    output logic [ADDR_W-1:0] ram_rd_addr_o,
    output logic              ram_rd_en_o,
    output logic [ADDR_W-1:0] ram_wr_addr_o,
    output logic [31:0]       ram_wr_data_o,
    output logic [3:0]        ram_wr_strb_o,
    input  logic [31:0]       ram_rd_data_i
);

    logic [31:0]       off0, off1, sel_off;
    logic              in0, in1, sel_in;
    logic              gnt0, gnt1, any_gnt;
    logic              sel_we;
    logic [3:0]        sel_strb;
    logic [31:0]       sel_wdata;
    logic [ADDR_W-1:0] sel_word;
    logic [31:0]       resp_data;
    logic              unused_addr_lsb;

    logic        rd_pending_q, rd_pending_d;
    logic        rd_owner_q,   rd_owner_d;
    logic        rd_err_q,     rd_err_d;
    logic        rd_isrd_q,    rd_isrd_d;
    logic [31:0] p0_rdata_q,   p0_rdata_d;
    logic [31:0] p1_rdata_q,   p1_rdata_d;
`ifdef RAM_ARB_RR_EN
    logic        last_gnt_q,   last_gnt_d;
`endif

    assign off0 = p0_addr_i - BASE_ADDR;
    assign off1 = p1_addr_i - BASE_ADDR;
    assign in0  = (off0[31:ADDR_W+2] == '0);
    assign in1  = (off1[31:ADDR_W+2] == '0);
    assign unused_addr_lsb = ^{off0[1:0], off1[1:0]};

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!prog_busy_i) begin
            if (p0_req_i && p1_req_i) begin
`ifdef RAM_ARB_RR_EN
                // last_gnt_q=1 means P1 was granted last, so P0 takes the tie
                if (last_gnt_q) gnt0 = 1'b1;
                else            gnt1 = 1'b1;
`else
                gnt1 = 1'b1;
`endif
            end else begin
                gnt0 = p0_req_i;
                gnt1 = p1_req_i;
            end
        end
    end

    assign any_gnt   = gnt0 | gnt1;
    assign sel_off   = gnt1 ? off1 : off0;
    assign sel_in    = gnt1 ? in1 : in0;
    assign sel_we    = gnt1 ? p1_we_i : p0_we_i;
    assign sel_strb  = gnt1 ? p1_strb_i : p0_strb_i;
    assign sel_wdata = gnt1 ? p1_wdata_i : p0_wdata_i;
    assign sel_word  = sel_off[ADDR_W+1:2];

    assign p0_gnt_o      = gnt0;
    assign p1_gnt_o      = gnt1;
    assign ram_rd_en_o   = any_gnt & ~sel_we & sel_in;
    assign ram_rd_addr_o = sel_word;
    assign ram_wr_addr_o = sel_word;
    assign ram_wr_data_o = sel_wdata;
    assign ram_wr_strb_o = (any_gnt && sel_we && sel_in) ? sel_strb : 4'b0000;

    // Write acks and out-of-range responses return zero data
    assign resp_data   = rd_isrd_q ? ram_rd_data_i : 32'h0;
    assign p0_rvalid_o = rd_pending_q & ~rd_owner_q;
    assign p1_rvalid_o = rd_pending_q &  rd_owner_q;
    assign p0_err_o    = p0_rvalid_o & rd_err_q;
    assign p1_err_o    = p1_rvalid_o & rd_err_q;
    assign p0_rdata_o  = p0_rvalid_o ? resp_data : p0_rdata_q;
    assign p1_rdata_o  = p1_rvalid_o ? resp_data : p1_rdata_q;

    always_comb begin
        rd_pending_d = any_gnt;
        rd_owner_d   = any_gnt ? gnt1 : rd_owner_q;
        rd_err_d     = any_gnt & ~sel_in;
        rd_isrd_d    = any_gnt & ~sel_we & sel_in;
        p0_rdata_d   = p0_rdata_o;
        p1_rdata_d   = p1_rdata_o;
`ifdef RAM_ARB_RR_EN
        last_gnt_d   = any_gnt ? gnt1 : last_gnt_q;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_pending_q <= 1'b0;
            rd_owner_q   <= 1'b0;
            rd_err_q     <= 1'b0;
            rd_isrd_q    <= 1'b0;
            p0_rdata_q   <= 32'h0;
            p1_rdata_q   <= 32'h0;
`ifdef RAM_ARB_RR_EN
            last_gnt_q   <= 1'b1;
`endif
        end else begin
            rd_pending_q <= rd_pending_d;
            rd_owner_q   <= rd_owner_d;
            rd_err_q     <= rd_err_d;
            rd_isrd_q    <= rd_isrd_d;
            p0_rdata_q   <= p0_rdata_d;
            p1_rdata_q   <= p1_rdata_d;
`ifdef RAM_ARB_RR_EN
            last_gnt_q   <= last_gnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_teknofest_ram_arbiter.sv
// Directed plus random bench for teknofest_ram_arbiter with a transaction-level reference model.
module tb_teknofest_ram_arbiter;

    localparam logic [31:0] BASE  = 32'h4000_0000;
    localparam int          WORDS = 131072;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        prog_busy;
    logic        req [2];
    logic        we [2];
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [3:0]  strb [2];
    logic        gnt [2];
    logic        rvalid [2];
    logic [31:0] rdata [2];
    logic        err [2];
    logic [16:0] ram_rd_addr, ram_wr_addr;
    logic        ram_rd_en;
    logic [31:0] ram_wr_data;
    logic [3:0]  ram_wr_strb;
    logic [31:0] ram_rd_data = 32'h0;

    bit [31:0] ram_mem [WORDS];
    bit [31:0] ref_mem [WORDS];
    logic        exp_vld [2];
    logic        exp_err [2];
    logic [31:0] exp_rdata [2];
    int          ref_last;
    int          gnt_port;
    logic        snap_gnt [2];
    logic        snap_rvalid [2];
    logic        snap_err [2];
    logic [31:0] snap_rdata [2];
    logic        snap_rd_en;
    logic [31:0] snap_rd_addr;
    int          n_checks = 0;
    int          n_fail = 0;
    int          seq [4];

    always #5 clk_i = ~clk_i;

    teknofest_ram_arbiter dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .prog_busy_i(prog_busy),
        .p0_req_i(req[0]), .p0_we_i(we[0]), .p0_addr_i(addr[0]), .p0_wdata_i(wdata[0]),
        .p0_strb_i(strb[0]), .p0_gnt_o(gnt[0]), .p0_rvalid_o(rvalid[0]), .p0_rdata_o(rdata[0]),
        .p0_err_o(err[0]),
        .p1_req_i(req[1]), .p1_we_i(we[1]), .p1_addr_i(addr[1]), .p1_wdata_i(wdata[1]),
        .p1_strb_i(strb[1]), .p1_gnt_o(gnt[1]), .p1_rvalid_o(rvalid[1]), .p1_rdata_o(rdata[1]),
        .p1_err_o(err[1]),
        .ram_rd_addr_o(ram_rd_addr), .ram_rd_en_o(ram_rd_en), .ram_wr_addr_o(ram_wr_addr),
        .ram_wr_data_o(ram_wr_data), .ram_wr_strb_o(ram_wr_strb), .ram_rd_data_i(ram_rd_data)
    );

    function automatic bit [31:0] merge(input bit [31:0] old, input bit [31:0] nw, input bit [3:0] s);
        bit [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    // RAM with registered read port; a write lands at the edge, visible to the next cycle's read
    always @(posedge clk_i) begin
        if (ram_rd_en) ram_rd_data <= ram_mem[ram_rd_addr];
        if (ram_wr_strb != 4'b0000)
            ram_mem[ram_wr_addr] <= merge(ram_mem[ram_wr_addr], ram_wr_data, ram_wr_strb);
    end

    function automatic bit ref_in_range(input logic [31:0] a);
        return (a - BASE) < 32'h0008_0000;
    endfunction

    function automatic int ref_word(input logic [31:0] a);
        return int'((a - BASE) >> 2) % WORDS;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            exp_vld[p] = 1'b0; exp_err[p] = 1'b0; exp_rdata[p] = 32'h0;
        end
        ref_last = 1;
    endtask

    task automatic tick();
        int g;
        bit inr;
        int w;
        logic exp_rd_en;
        logic [3:0] exp_strb;
        @(negedge clk_i);
        g = -1;
        if (!prog_busy) begin
            if (req[0] && req[1]) begin
`ifdef RAM_ARB_RR_EN
                g = (ref_last == 1) ? 0 : 1;
`else
                g = 1;
`endif
            end else if (req[0]) g = 0;
            else if (req[1]) g = 1;
        end
        inr = 1'b0; w = 0; exp_rd_en = 1'b0; exp_strb = 4'b0000;
        if (g >= 0) begin
            inr = ref_in_range(addr[g]);
            w = ref_word(addr[g]);
            exp_rd_en = !we[g] && inr;
            exp_strb = (we[g] && inr) ? strb[g] : 4'b0000;
        end
        for (int p = 0; p < 2; p++) begin
            snap_gnt[p] = gnt[p]; snap_rvalid[p] = rvalid[p];
            snap_err[p] = err[p]; snap_rdata[p] = rdata[p];
            chk($sformatf("p%0d_gnt", p), gnt[p], (g == p));
            chk($sformatf("p%0d_rvalid", p), rvalid[p], exp_vld[p]);
            chk($sformatf("p%0d_err", p), err[p], exp_err[p]);
            chk($sformatf("p%0d_rdata", p), rdata[p], exp_rdata[p]);
        end
        snap_rd_en = ram_rd_en; snap_rd_addr = 32'(ram_rd_addr);
        chk("ram_rd_en", ram_rd_en, exp_rd_en);
        chk("ram_wr_strb", ram_wr_strb, exp_strb);
        if (exp_rd_en) chk("ram_rd_addr", ram_rd_addr, w);
        if (exp_strb != 4'b0000) begin
            chk("ram_wr_addr", ram_wr_addr, w);
            chk("ram_wr_data", ram_wr_data, wdata[g]);
        end
        @(posedge clk_i);
        if (rst_ni) begin
            for (int p = 0; p < 2; p++) begin
                exp_vld[p] = (g == p);
                exp_err[p] = (g == p) && !inr;
                if (g == p) exp_rdata[p] = (!inr || we[p]) ? 32'h0 : ref_mem[w];
            end
            if (g >= 0 && we[g] && inr) ref_mem[w] = merge(ref_mem[w], wdata[g], strb[g]);
            if (g >= 0) ref_last = g;
        end
        gnt_port = g;
        #1;
    endtask

    task automatic idle();
        req[0] = 1'b0; req[1] = 1'b0;
    endtask

    task automatic drive(input int p, input logic w_e, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        req[p] = 1'b1; we[p] = w_e; addr[p] = a; wdata[p] = d; strb[p] = s;
    endtask

    initial begin
        rst_ni = 1'b0; prog_busy = 1'b0;
        for (int p = 0; p < 2; p++) begin
            req[p] = 1'b0; we[p] = 1'b0; addr[p] = 32'h0; wdata[p] = 32'h0; strb[p] = 4'h0;
        end
        for (int i = 0; i < 64; i++) begin
            ram_mem[i] = $urandom; ref_mem[i] = ram_mem[i];
        end
        ram_mem[4] = 32'hDEAD_BEEF; ref_mem[4] = 32'hDEAD_BEEF;
        ram_mem[2] = 32'hAABB_CCDD; ref_mem[2] = 32'hAABB_CCDD;
        model_reset();

        #3;
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("rst_p%0d_rvalid", p), rvalid[p], 1'b0);
            chk($sformatf("rst_p%0d_err", p), err[p], 1'b0);
            chk($sformatf("rst_p%0d_rdata", p), rdata[p], 32'h0);
        end
        chk("rst_rd_en", ram_rd_en, 1'b0);
        chk("rst_strb", ram_wr_strb, 4'b0000);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;

        // Fetch read of word 4
        drive(0, 1'b0, 32'h4000_0010, 32'h0, 4'h0);
        tick();
        chk("t1_gnt0", snap_gnt[0], 1'b1);
        chk("t1_rd_addr", snap_rd_addr, 32'd4);
        idle(); tick();
        chk("t1_rvalid0", snap_rvalid[0], 1'b1);
        chk("t1_rdata0", snap_rdata[0], 32'hDEAD_BEEF);
        chk("t1_rvalid1", snap_rvalid[1], 1'b0);

        // Partial write then read-back of word 2
        drive(1, 1'b1, 32'h4000_0008, 32'h1122_3344, 4'b0011);
        tick();
        drive(1, 1'b0, 32'h4000_0008, 32'h0, 4'h0);
        tick();
        chk("t2_wack", snap_rvalid[1], 1'b1);
        chk("t2_wack_data", snap_rdata[1], 32'h0);
        idle(); tick();
        chk("t2_rdata1", snap_rdata[1], 32'hAABB_3344);

        // Continuous contention
        drive(0, 1'b0, 32'h4000_0020, 32'h0, 4'h0);
        drive(1, 1'b0, 32'h4000_0024, 32'h0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            seq[i] = gnt_port;
            chk($sformatf("t3_p1_gnt_%0d", i), snap_gnt[1],
`ifdef RAM_ARB_RR_EN
                (i % 2 == 1)
`else
                1'b1
`endif
            );
        end
        idle(); tick();

        // Below-base access
        drive(1, 1'b0, 32'h3FFF_FFFC, 32'h0, 4'h0);
        tick();
        chk("t4_gnt1", snap_gnt[1], 1'b1);
        chk("t4_rd_en", snap_rd_en, 1'b0);
        idle(); tick();
        chk("t4_rvalid1", snap_rvalid[1], 1'b1);
        chk("t4_err1", snap_err[1], 1'b1);
        chk("t4_rdata1", snap_rdata[1], 32'h0);

        // Reprogramming blocks everything
        prog_busy = 1'b1;
        drive(0, 1'b1, 32'h4000_0030, 32'hCAFE_0000, 4'hF);
        drive(1, 1'b1, 32'h4000_0034, 32'hCAFE_0001, 4'hF);
        for (int i = 0; i < 10; i++) tick();
        prog_busy = 1'b0;
        tick();
        chk("t5_first_gnt", (gnt_port >= 0), 1'b1);
        idle(); tick();

        // Reset in the cycle after a read grant
        drive(0, 1'b0, 32'h4000_0010, 32'h0, 4'h0);
        tick();
        idle();
        rst_ni = 1'b0;
        model_reset();
        #1;
        chk("t6_rvalid0_in_rst", rvalid[0], 1'b0);
        tick();
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("t6_no_rvalid0_%0d", i), snap_rvalid[0], 1'b0);
            chk($sformatf("t6_no_rvalid1_%0d", i), snap_rvalid[1], 1'b0);
        end

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            prog_busy = ($urandom_range(9) == 0);
            for (int p = 0; p < 2; p++) begin
                req[p] = ($urandom_range(9) < 7);
                we[p] = $urandom_range(1);
                addr[p] = ($urandom_range(9) == 0) ? 32'($urandom)
                        : BASE + 32'($urandom_range(63) * 4) + 32'($urandom_range(3));
                wdata[p] = $urandom;
                strb[p] = 4'($urandom_range(15));
            end
            tick();
        end
        idle(); prog_busy = 1'b0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
